// File: rtl/light_effect_engine.sv
// light_effect_engine
//
// Takes the 24-bit light word from the LED driver stage and produces the
// registered LED pin vector. One of four effects is applied:
//   mode 00 pass-through, 01 blink, 10 PWM dim, 11 rotate-scroll.
// Effect registers are written over the shared IO write path. The block is
// selected by iDoEffectWrite.
//
// Optional feature: define LIGHT_EFFECT_READBACK_EN to add the iDoIORead
// input and the combinational oEffectReadData register readback output.
//
// Ports:
//   iCpuClock           clock, all flops on the rising edge
//   iCpuReset           synchronous active-low reset
//   iDoIOWrite          IO write strobe
//   iDoEffectWrite      effect-block chip select
//   iEffectAddress      00 mode, 01 period, 10 duty, 11 reserved
//   iEffectDataToWrite  write data
//   iLightPattern       light word from the LED driver stage
//   iDoIORead           (readback build only) IO read strobe
//   oEffectReadData     (readback build only) register readback
//   oFpgaLights         registered LED pin vector
//   oEffectTick         one-cycle prescaler tick pulse

module light_effect_engine #(
    parameter logic [15:0] DEFAULT_PERIOD = 16'd49999,
    parameter logic [7:0]  DEFAULT_DUTY   = 8'h80
) (
    input  logic        iCpuClock,
    input  logic        iCpuReset,
    input  logic        iDoIOWrite,
    input  logic        iDoEffectWrite,
    input  logic [1:0]  iEffectAddress,
    input  logic [15:0] iEffectDataToWrite,
    input  logic [23:0] iLightPattern,
`ifdef LIGHT_EFFECT_READBACK_EN
    input  logic        iDoIORead,
    output logic [15:0] oEffectReadData,
`endif
    output logic [23:0] oFpgaLights,
    output logic        oEffectTick
);

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_DIM    = 2'b10;
    localparam logic [1:0] MODE_SCROLL = 2'b11;

    localparam logic [1:0] ADDR_MODE   = 2'b00;
    localparam logic [1:0] ADDR_PERIOD = 2'b01;
    localparam logic [1:0] ADDR_DUTY   = 2'b10;

    logic [1:0]  mode_q,   mode_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  duty_q,   duty_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic        phase_q,  phase_d;
    logic [23:0] rot_q,    rot_d;
    logic [23:0] shadow_q, shadow_d;
    logic [23:0] lights_q, lights_d;
    logic        tick_q,   tick_d;

    logic wr_en;
    logic mode_wr;
    logic tick_hit;

    assign wr_en    = iDoIOWrite & iDoEffectWrite;
    assign mode_wr  = wr_en && (iEffectAddress == ADDR_MODE);
    assign tick_hit = (cnt_q == period_q);

    always_comb begin
        mode_d    = mode_q;
        period_d  = period_q;
        duty_d    = duty_q;
        cnt_d     = cnt_q;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        phase_d   = phase_q;
        rot_d     = rot_q;
        shadow_d  = shadow_q;
        tick_d    = 1'b0;
        lights_d  = 24'h0;

        if (wr_en) begin
            case (iEffectAddress)
                ADDR_MODE:   mode_d   = iEffectDataToWrite[1:0];
                ADDR_PERIOD: period_d = iEffectDataToWrite;
                ADDR_DUTY:   duty_d   = iEffectDataToWrite[7:0];
                default:     ;
            endcase
        end

        // A mode write restarts every effect from a known point and
        // swallows a tick landing on the same edge.
        if (mode_wr) begin
            cnt_d     = 16'h0;
            pwm_cnt_d = 8'h0;
            phase_d   = 1'b1;
            rot_d     = iLightPattern;
            shadow_d  = iLightPattern;
        end else begin
            if (tick_hit) begin
                cnt_d   = 16'h0;
                tick_d  = 1'b1;
                phase_d = ~phase_q;
            end else begin
                // Period lowered below cnt: let cnt wrap through 16'hFFFF.
                cnt_d = cnt_q + 16'd1;
            end

            if (mode_q == MODE_SCROLL) begin
                // A new input word restarts the scroll, beating any rotate.
                if (iLightPattern != shadow_q) begin
                    rot_d    = iLightPattern;
                    shadow_d = iLightPattern;
                end else if (tick_hit) begin
                    rot_d = {rot_q[22:0], rot_q[23]};
                end
            end else begin
                shadow_d = iLightPattern;
            end
        end

        // Output uses the mode/phase in effect before this edge.
        case (mode_q)
            MODE_PASS:   lights_d = iLightPattern;
            MODE_BLINK:  lights_d = phase_q ? iLightPattern : 24'h0;
            MODE_DIM:    lights_d = (pwm_cnt_q < duty_q) ? iLightPattern : 24'h0;
            MODE_SCROLL: lights_d = rot_q;
            default:     lights_d = 24'h0;
        endcase
    end

    always_ff @(posedge iCpuClock) begin
        if (!iCpuReset) begin
            mode_q    <= MODE_PASS;
            period_q  <= DEFAULT_PERIOD;
            duty_q    <= DEFAULT_DUTY;
            cnt_q     <= 16'h0;
            pwm_cnt_q <= 8'h0;
            phase_q   <= 1'b1;
            rot_q     <= 24'h0;
            shadow_q  <= 24'h0;
            lights_q  <= 24'h0;
            tick_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            cnt_q     <= cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            phase_q   <= phase_d;
            rot_q     <= rot_d;
            shadow_q  <= shadow_d;
            lights_q  <= lights_d;
            tick_q    <= tick_d;
        end
    end

    assign oFpgaLights = lights_q;
    assign oEffectTick = tick_q;

`ifdef LIGHT_EFFECT_READBACK_EN
    always_comb begin
        oEffectReadData = 16'h0;
        if (iDoIORead && iDoEffectWrite) begin
            case (iEffectAddress)
                ADDR_MODE:   oEffectReadData = {14'b0, mode_q};
                ADDR_PERIOD: oEffectReadData = period_q;
                ADDR_DUTY:   oEffectReadData = {8'b0, duty_q};
                default:     oEffectReadData = 16'h0;
            endcase
        end
    end
`endif

endmodule
